// File: rtl/sinc3_decimator.sv
// Third-order CIC decimator for a 1-bit sigma-delta stream.
// Emits saturated, settled PCM samples through a 2-entry valid/ready buffer.
module sinc3_decimator #(
  parameter int unsigned OSR       = 32,
  parameter int unsigned OUT_WIDTH = 3*$clog2(OSR)+1,
  parameter int unsigned SETTLE    = 3
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        en,
  input  logic                        in,
  input  logic                        clrOverflow,
  input  logic                        outReady,
  output logic signed [OUT_WIDTH-1:0] outData,
  output logic                        outValid,
  output logic                        overflow
);

  localparam int unsigned IW = 3*$clog2(OSR)+2;
  localparam int unsigned CW = $clog2(OSR);
  localparam logic [CW-1:0] CNT_MAX  = CW'(OSR-1);
  localparam logic [1:0]    SETTLE_N = 2'(SETTLE);
  localparam logic signed [IW-1:0] SAT_HI =
    {{(IW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
  localparam logic signed [IW-1:0] SAT_LO =
    {{(IW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

  logic signed [IW-1:0] i1, i2, i3;
  logic signed [IW-1:0] i1_n, i2_n, i3_n, x;
  logic [CW-1:0]        cnt;
  logic                 tick;

  logic signed [IW-1:0] cin, y1, y2, y3, d1, d2, d3;
  logic                 v0, v1, v2, v3;
  logic [1:0]           settle_cnt;
  logic                 settled, push, pop, drop;
  logic signed [OUT_WIDTH-1:0] sat;
  logic signed [OUT_WIDTH-1:0] tail;
  logic                 tail_v;

  // Single-cycle integrator cascade on the updated values
  always_comb begin
    x    = in ? IW'(1) : '1;
    i1_n = i1 + x;
    i2_n = i2 + i1_n;
    i3_n = i3 + i2_n;
    tick = en & (cnt == CNT_MAX);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i1  <= '0;
      i2  <= '0;
      i3  <= '0;
      cnt <= '0;
      cin <= '0;
      v0  <= 1'b0;
    end else begin
      v0 <= tick;
      if (en) begin
        i1  <= i1_n;
        i2  <= i2_n;
        i3  <= i3_n;
        cnt <= (cnt == CNT_MAX) ? '0 : cnt + CW'(1);
      end
      if (tick) cin <= i3_n;
    end
  end

  // Comb pipeline runs on the valid bit only, independent of en
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y1 <= '0; y2 <= '0; y3 <= '0;
      d1 <= '0; d2 <= '0; d3 <= '0;
      v1 <= 1'b0; v2 <= 1'b0; v3 <= 1'b0;
    end else begin
      v1 <= v0;
      v2 <= v1;
      v3 <= v2;
      if (v0) begin
        y1 <= cin - d1;
        d1 <= cin;
      end
      if (v1) begin
        y2 <= y1 - d2;
        d2 <= y1;
      end
      if (v2) begin
        y3 <= y2 - d3;
        d3 <= y2;
      end
    end
  end

  always_comb begin
    sat = OUT_WIDTH'(y3);
    if (y3 > SAT_HI)      sat = OUT_WIDTH'(SAT_HI);
    else if (y3 < SAT_LO) sat = OUT_WIDTH'(SAT_LO);
  end

  assign settled = (settle_cnt == SETTLE_N);
  assign push    = v3 & settled;
  assign pop     = outValid & outReady;
  assign drop    = push & ~pop & tail_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) settle_cnt <= '0;
    else if (v3 && !settled) settle_cnt <= settle_cnt + 2'd1;
  end

  // Two-entry buffer: outData/outValid is the head slot, tail holds the second
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outData  <= '0;
      outValid <= 1'b0;
      tail     <= '0;
      tail_v   <= 1'b0;
      overflow <= 1'b0;
    end else begin
      overflow <= drop | (overflow & ~clrOverflow);
      if (pop) begin
        if (tail_v) begin
          outData <= tail;
          if (push) tail   <= sat;
          else      tail_v <= 1'b0;
        end else if (push) begin
          outData <= sat;
        end else begin
          outValid <= 1'b0;
        end
      end else if (push) begin
        if (!outValid) begin
          outData  <= sat;
          outValid <= 1'b1;
        end else if (!tail_v) begin
          tail   <= sat;
          tail_v <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sinc3_decimator.sv
// Bench for sinc3_decimator: impulse-response reference model plus directed checks.
module tb_sinc3_decimator;

  localparam int R  = 32;
  localparam int OW = 16;
  localparam int IW = 17;
  localparam int ST = 3;
  localparam int HL = 3*R-2;

  logic clk = 1'b0;
  logic rst, en, in, clrOverflow, outReady;
  logic signed [OW-1:0] outData;
  logic outValid, overflow;

  sinc3_decimator #(.OSR(R), .OUT_WIDTH(OW), .SETTLE(ST)) dut (
    .clk(clk), .rst(rst), .en(en), .in(in), .clrOverflow(clrOverflow),
    .outReady(outReady), .outData(outData), .outValid(outValid), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_on = 1'b0;

  task automatic cmp(string nm, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference: sinc^3 impulse response convolved with the consumed +/-1 samples
  int h[HL];
  int hist[$];
  int mcnt, mset, cyc;
  bit mov;
  int mq[$];
  int pv[$];
  int pd[$];
  bit m_pop, m_drop;
  int m_v;
  longint m_acc;
  logic signed [IW-1:0] m_w;

  function automatic int model_sample();
    longint acc = 0;
    int s;
    for (int k = 0; k < hist.size(); k++) acc += longint'(h[k]) * longint'(hist[k]);
    m_w = IW'(acc);
    s = int'(m_w);
    if (s > (1 << (OW-1)) - 1) s = (1 << (OW-1)) - 1;
    if (s < -(1 << (OW-1)))    s = -(1 << (OW-1));
    return s;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      hist.delete(); mq.delete(); pv.delete(); pd.delete();
      mcnt = 0; mset = 0; mov = 1'b0;
    end else begin
      cyc++;
      m_pop  = (mq.size() > 0) && outReady;
      m_drop = 1'b0;
      if (m_pop) void'(mq.pop_front());
      if (pd.size() > 0 && pd[0] == cyc) begin
        m_v = pv.pop_front();
        void'(pd.pop_front());
        if (mset < ST)          mset++;
        else if (mq.size() < 2) mq.push_back(m_v);
        else                    m_drop = 1'b1;
      end
      mov = m_drop | (mov & !clrOverflow);
      if (en) begin
        hist.push_front(in ? 1 : -1);
        if (hist.size() > HL) void'(hist.pop_back());
        if (mcnt == R-1) begin
          pv.push_back(model_sample());
          pd.push_back(cyc + 4);
          mcnt = 0;
        end else begin
          mcnt++;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      cmp("outValid", int'(outValid), int'(mq.size() > 0));
      cmp("overflow", int'(overflow), int'(mov));
      if (mq.size() > 0) cmp("outData", int'(outData), mq[0]);
    end
  end

  // Stimulus
  int mode, ecnt;
  bit alt, pv_last;
  int rises[$];

  task automatic set_inputs();
    case (mode)
      0: begin en = 1'b1; in = 1'b1; end
      1: begin en = 1'b1; in = 1'b0; end
      2: begin en = 1'b1; in = alt; alt = ~alt; end
      default: begin
        en = (ecnt % 2 == 0);
        if (en) begin in = alt; alt = ~alt; end
      end
    endcase
  endtask

  task automatic run(int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      ecnt++;
      if (outValid && !pv_last) rises.push_back(ecnt);
      pv_last = outValid;
      set_inputs();
    end
  endtask

  task automatic hold_reset();
    #2 rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic start(int md, bit rdy);
    mode = md; outReady = rdy; clrOverflow = 1'b0;
    alt = 1'b1; ecnt = 0; pv_last = 1'b0;
    rises.delete();
    set_inputs();
    rst = 1'b0;
  endtask

  task automatic first_push(string nm, int exp);
    run(131);
    cmp({nm, "_early"}, int'(outValid), 0);
    run(1);
    cmp({nm, "_valid"}, int'(outValid), 1);
    cmp({nm, "_data"}, int'(outData), exp);
  endtask

  initial begin
    int sum;
    for (int k = 0; k < HL; k++) h[k] = 0;
    for (int a = 0; a < R; a++)
      for (int b = 0; b < R; b++)
        for (int c = 0; c < R; c++) h[a+b+c]++;
    sum = 0;
    for (int k = 0; k < HL; k++) sum += h[k];
    cmp("h_sum", sum, 32768);
    cmp("h_1", h[1], 3);
    cmp("h_31", h[31], 528);

    rst = 1'b0; en = 1'b0; in = 1'b0; clrOverflow = 1'b0; outReady = 1'b0;
    mode = 0; ecnt = 0; alt = 1'b1; pv_last = 1'b0;
    hold_reset();
    chk_on = 1'b1;
    cmp("rst_outData", int'(outData), 0);
    cmp("rst_outValid", int'(outValid), 0);
    cmp("rst_overflow", int'(overflow), 0);

    // Constant +1 saturates to the positive rail
    start(0, 1'b1);
    first_push("pos", 32767);
    run(140);

    // Constant -1 reaches the negative rail exactly
    hold_reset();
    start(1, 1'b1);
    first_push("neg", -32768);
    run(100);
    cmp("neg_overflow", int'(overflow), 0);

    // Alternating input is nulled
    hold_reset();
    start(2, 1'b1);
    first_push("alt", 0);
    run(100);

    // Alternating with en every other cycle: output spacing doubles
    hold_reset();
    start(3, 1'b1);
    run(400);
    cmp("en_rise_cnt", rises.size(), 3);
    if (rises.size() >= 2) begin
      cmp("en_first_rise", rises[0], 259);
      cmp("en_spacing", rises[1] - rises[0], 64);
    end
    cmp("en_data", int'(outData), 0);

    // Stalled consumer: two buffered, third dropped, then drain and clear
    hold_reset();
    start(0, 1'b0);
    run(196);
    cmp("stall_overflow", int'(overflow), 1);
    cmp("stall_valid", int'(outValid), 1);
    cmp("stall_data", int'(outData), 32767);
    outReady = 1'b1;
    run(1);
    cmp("drain1_valid", int'(outValid), 1);
    run(1);
    cmp("drain2_valid", int'(outValid), 0);
    cmp("drain_overflow", int'(overflow), 1);
    clrOverflow = 1'b1;
    run(1);
    clrOverflow = 1'b0;
    cmp("clr_overflow", int'(overflow), 0);
    run(10);

    // Pop and push together on a full buffer with distinct values
    hold_reset();
    start(0, 1'b0);
    run(140);
    mode = 1;
    run(55);
    outReady = 1'b1;
    run(1);
    outReady = 1'b0;
    cmp("pp_overflow", int'(overflow), 0);
    cmp("pp_valid", int'(outValid), 1);
    run(5);
    outReady = 1'b1;
    run(4);

    // Asynchronous reset mid-period with buffered data and overflow set
    hold_reset();
    start(0, 1'b0);
    run(208);
    #2 rst = 1'b1;
    #1;
    cmp("arst_outData", int'(outData), 0);
    cmp("arst_outValid", int'(outValid), 0);
    cmp("arst_overflow", int'(overflow), 0);
    @(negedge clk);
    start(0, 1'b1);
    first_push("post_rst", 32767);
    run(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/sinc3_decimator.md
# sinc3_decimator

Third-order CIC (sinc³) decimator that turns the 1-bit output of the second-order sigma-delta modulator into signed PCM samples at 1/OSR of the clock-enable rate. It sits directly downstream of the modulator. Unlike the free-running sinc3 filter, it produces only decimated samples, with settling suppression, output saturation and a 2-entry valid/ready output buffer so slower consumers can attach.

## Interface
- OSR, 32, decimation ratio; integer ≥ 4
- OUT_WIDTH, 3*$clog2(OSR)+1, output sample width (16 at OSR=32)
- SETTLE, 3, number of decimated results discarded after reset
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  input-sample enable; `in` is consumed only on cycles with en=1
- in  in  1  modulator bit; 1 → +1, 0 → −1
- clrOverflow  in  1  synchronous clear of `overflow`
- outReady  in  1  consumer accepts the head sample
- outData  out  OUT_WIDTH  signed decimated sample (head of buffer)
- outValid  out  1  outData is valid
- overflow  out  1  sticky; a sample was dropped because the buffer was full

## Operation
- Internal width IW = 3*$clog2(OSR)+2. All integrator and comb arithmetic is two's-complement modulo 2^IW, and wrap is intentional.
- Integrators I1..I3 are cleared on reset. On en=1:
  - I1 += x
  - I2 += I1_new
  - I3 += I2_new
  - x = ±1 sign-extended. Chaining uses the updated values, as in a single-cycle cascade.
- Decimation counter `cnt` counts 0..OSR-1 and advances only on en=1, wrapping to 0.
- tick = en & (cnt==OSR-1).
- On tick, the post-update value of I3 is captured into the comb input register, and a pipeline valid bit is set.
- Comb stages C1..C3 each compute y = u − u_delay, then set u_delay ← u. Each stage takes one clock and advances every clock with pipeline valid, independent of en. Delay registers update only when their stage is valid.
- Saturation stage: the IW-bit comb result is clamped to [−2^(OUT_WIDTH−1), 2^(OUT_WIDTH−1)−1]. Full-scale +OSR³ (e.g. +32768) becomes 32767; −OSR³ fits exactly.
- Settling: the first SETTLE saturated results after reset are discarded and never pushed. A 2-bit counter tracks this and then saturates.
- Output buffer is a 2-entry FIFO:
  - A push and a pop (outValid & outReady) in the same cycle are both honoured.
  - A push when the buffer holds 2 entries and there is no pop drops the new sample and sets `overflow`.
- `overflow` stays set until clrOverflow=1 or reset. If clrOverflow and a new drop occur in the same cycle, overflow ends the cycle set.

## Timing
- Reset values:
  - outData=0, outValid=0, overflow=0
  - I1..I3=0, combs=0, cnt=0, settle count=0, FIFO empty
- Latency: a FIFO push happens on the 4th rising edge after the tick edge. That is 1 comb-input + 3 comb clocks, with saturation combinational into the push. outValid goes high after that edge.
- Because OSR ≥ 4, at most one sample is in the comb pipeline at a time.
- Steady-state output rate is one sample per OSR enabled cycles.
- outData/outValid are registered head-of-FIFO. After a pop, the next entry (if any) appears the following cycle with no bubble.
- en=0 freezes the integrators and cnt. A sample already in the comb pipeline still completes.
- Reset mid-operation:
  - The in-flight sample is lost.
  - The FIFO is emptied and the settle count restarts, so the next SETTLE results are discarded again.

## Test plan
- Constant in=1, en=1, outReady=1, OSR=32: the first 3 results are suppressed. Every subsequent outData=32767 (saturated +32768), one per 32 clocks, with outValid arriving 4 edges after each tick.
- Constant in=0: after settling every outData=−32768, and overflow stays 0.
- Alternating 1,0,1,0…: after settling every outData=0. Repeat with en toggling every other cycle: outputs are still 0, spaced 64 clocks apart.
- outReady=0 with in=1: after settling exactly 2 samples (32767) are buffered and the 3rd push sets overflow. Then raise outReady: 2 samples pop on consecutive cycles and outValid drops. Pulse clrOverflow → overflow=0.
- Assert rst for 1 cycle halfway through a decimation period with buffered data: all outputs read 0 immediately (asynchronous). The next 3 results after release are suppressed.
- Pop and push in the same cycle with the buffer full: no drop, overflow unchanged, ordering preserved.
